// File: rtl/pn9_burst_ctrl.sv
// pn9_burst_ctrl: runs one burst of PN9 words from an external LFSR datapath,
// buffering them in a small FIFO with a last-word tag and a valid/ready output.
// The datapath cannot stall, so backpressure that fills the FIFO is an
// overrun error that ends the burst.
// Optional: define PN9_BURST_CNT_EN to add a 16-bit completed-burst counter
// output (burst_cnt).
module pn9_burst_ctrl #(
    parameter int BURST_W    = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               mode_sel,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    output logic               pn_enable,
    output logic               pn_mode,
    input  logic [15:0]        pn_data,
    output logic [15:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last
`ifdef PN9_BURST_CNT_EN
    ,
    output logic [15:0]        burst_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic               pn_enable_q, pn_enable_d;
    logic               pn_mode_q,   pn_mode_d;
    logic               done_q,      done_d;
    logic               overrun_q,   overrun_d;
    logic [AW-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]      count_q,     count_d;
`ifdef PN9_BURST_CNT_EN
    logic [15:0]        burst_cnt_q, burst_cnt_d;
`endif

    // Word storage; no reset needed since head is masked while empty.
    logic [15:0] data_mem [FIFO_DEPTH];
    logic        last_mem [FIFO_DEPTH];

    logic push;
    logic pop;
    logic full;
    logic ovf;
    logic wr_en;
    logic push_last;

    // FIFO handshake and error detection. The first RUN cycle only raises
    // pn_enable, so words are taken only once the datapath is running.
    always_comb begin
        push      = (state_q == ST_RUN) && pn_enable_q;
        pop       = (count_q != '0) && out_ready;
        full      = (count_q == CW'(FIFO_DEPTH));
        ovf       = push && full && !pop;
        wr_en     = push && !ovf && !abort;
        push_last = (remaining_q == BURST_W'(1));
    end

    // Next-state logic: abort, then overrun, then normal sequencing.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pn_enable_d = pn_enable_q;
        pn_mode_d   = pn_mode_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (abort) begin
            state_d     = ST_IDLE;
            pn_enable_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end else if (ovf) begin
            overrun_d   = 1'b1;
            state_d     = ST_IDLE;
            pn_enable_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(wr_en);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + CW'(wr_en) - CW'(pop);

            case (state_q)
                ST_IDLE: begin
                    pn_enable_d = 1'b0;
                    if (start) begin
                        remaining_d = burst_len;
                        pn_mode_d   = mode_sel;
                        overrun_d   = 1'b0;
                        if (burst_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!pn_enable_q) begin
                        pn_enable_d = 1'b1;
                    end else begin
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - BURST_W'(1);
                        end
                        if (remaining_q <= BURST_W'(1)) begin
                            state_d     = ST_DRAIN;
                            pn_enable_d = 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    pn_enable_d = 1'b0;
                    if (count_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    pn_enable_d = 1'b0;
                end
            endcase
        end
    end

`ifdef PN9_BURST_CNT_EN
    // Count every completed burst, wrapping at 16 bits.
    always_comb begin
        burst_cnt_d = burst_cnt_q + 16'(done_d);
    end
`endif

    // Control and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            pn_enable_q <= 1'b0;
            pn_mode_q   <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef PN9_BURST_CNT_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pn_enable_q <= pn_enable_d;
            pn_mode_q   <= pn_mode_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
`ifdef PN9_BURST_CNT_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    // Word store: capture the presented datapath word and its last tag.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            data_mem[wr_ptr_q] <= pn_data;
            last_mem[wr_ptr_q] <= push_last;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign pn_enable = pn_enable_q;
    assign pn_mode   = pn_mode_q;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? data_mem[rd_ptr_q] : 16'h0000;
    assign out_last  = out_valid ? last_mem[rd_ptr_q] : 1'b0;
`ifdef PN9_BURST_CNT_EN
    assign burst_cnt = burst_cnt_q;
`endif

endmodule

// File: tb/tb_pn9_burst_ctrl.sv
// Directed bench for pn9_burst_ctrl with a simple datapath stand-in that
// replays a fixed word table while enabled and reseeds when disabled.
module tb_pn9_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [11:0] burst_len;
    logic        mode_sel;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        pn_enable;
    logic        pn_mode;
    logic [15:0] pn_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
`ifdef PN9_BURST_CNT_EN
    logic [15:0] burst_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    pn9_burst_ctrl #(.BURST_W(12), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .burst_len (burst_len),
        .mode_sel  (mode_sel),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .pn_enable (pn_enable),
        .pn_mode   (pn_mode),
        .pn_data   (pn_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef PN9_BURST_CNT_EN
        ,
        .burst_cnt (burst_cnt)
`endif
    );

    // Datapath stand-in: index 0 is the all-ones seed.
    function automatic logic [15:0] pn_word(input logic [2:0] i);
        case (i)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'h07BE;
            3'd2:    return 16'h1234;
            3'd3:    return 16'hABCD;
            3'd4:    return 16'h5A5A;
            3'd5:    return 16'hC3C3;
            3'd6:    return 16'h0F0F;
            default: return 16'hF0F0;
        endcase
    endfunction

    logic [2:0] pn_idx = 3'd0;
    always @(posedge clk) begin
        pn_idx <= pn_enable ? pn_idx + 3'd1 : 3'd0;
    end
    assign pn_data = pn_word(pn_idx) & (pn_mode ? 16'hFFFF : 16'hFFFC);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_done(input string tag, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk(tag, {15'd0, seen}, 16'd1);
    endtask

    task automatic kick(input logic [11:0] len, input logic m);
        burst_len = len;
        mode_sel  = m;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        burst_len = '0; mode_sel = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_busy",   {15'd0, busy},      16'd0);
        chk("rst_valid",  {15'd0, out_valid}, 16'd0);
        chk("rst_pnen",   {15'd0, pn_enable}, 16'd0);
        chk("rst_data",   out_data,           16'h0000);
        reset = 1'b0;
        step();

        // 1: two 16-bit words, free-flowing output
        out_ready = 1'b1;
        kick(12'd2, 1'b1);
        chk("t1_busy",    {15'd0, busy},      16'd1);
        chk("t1_pnen0",   {15'd0, pn_enable}, 16'd0);
        chk("t1_mode",    {15'd0, pn_mode},   16'd1);
        step();
        chk("t1_pnen1",   {15'd0, pn_enable}, 16'd1);
        chk("t1_nvalid",  {15'd0, out_valid}, 16'd0);
        step();
        chk("t1_w0",      out_data,           16'hFFFF);
        chk("t1_w0_last", {15'd0, out_last},  16'd0);
        chk("t1_w0_vld",  {15'd0, out_valid}, 16'd1);
        step();
        chk("t1_w1",      out_data,           16'h07BE);
        chk("t1_w1_last", {15'd0, out_last},  16'd1);
        chk("t1_pnen_dn", {15'd0, pn_enable}, 16'd0);
        step();
        chk("t1_empty",   {15'd0, out_valid}, 16'd0);
        chk("t1_nodone",  {15'd0, done},      16'd0);
        step();
        chk("t1_done",    {15'd0, done},      16'd1);
        chk("t1_idle",    {15'd0, busy},      16'd0);
        step();
        chk("t1_done_1c", {15'd0, done},      16'd0);

        // 2: single 14-bit word
        kick(12'd1, 1'b0);
        chk("t2_mode_a",  {15'd0, pn_mode},   16'd0);
        step(); step();
        chk("t2_w0",      out_data,           16'hFFFC);
        chk("t2_last",    {15'd0, out_last},  16'd1);
        chk("t2_mode_b",  {15'd0, pn_mode},   16'd0);
        step();
        chk("t2_empty",   {15'd0, out_valid}, 16'd0);
        step();
        chk("t2_done",    {15'd0, done},      16'd1);
        step();

        // 3: four words held back by a stalled consumer
        out_ready = 1'b0;
        kick(12'd4, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk("t3_ovr",     {15'd0, overrun},   16'd0);
        chk("t3_valid",   {15'd0, out_valid}, 16'd1);
        chk("t3_busy",    {15'd0, busy},      16'd1);
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b1;
        begin
            logic [15:0] exp_w [4];
            exp_w[0] = 16'hFFFF; exp_w[1] = 16'h07BE;
            exp_w[2] = 16'h1234; exp_w[3] = 16'hABCD;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t3_w%0d", k), out_data, exp_w[k]);
                chk($sformatf("t3_last%0d", k), {15'd0, out_last}, {15'd0, k == 3});
                step();
            end
        end
        chk("t3_empty",   {15'd0, out_valid}, 16'd0);
        chk("t3_nodone",  {15'd0, done},      16'd0);
        step();
        chk("t3_done",    {15'd0, done},      16'd1);
        chk("t3_ovr_end", {15'd0, overrun},   16'd0);
        step();

        // 4: eight words into a stalled consumer -> overrun on fifth push
        out_ready = 1'b0;
        kick(12'd8, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk("t4_pre_ovr", {15'd0, overrun},   16'd0);
        chk("t4_pre_bsy", {15'd0, busy},      16'd1);
        step();
        chk("t4_ovr",     {15'd0, overrun},   16'd1);
        chk("t4_valid",   {15'd0, out_valid}, 16'd0);
        chk("t4_busy",    {15'd0, busy},      16'd0);
        chk("t4_pnen",    {15'd0, pn_enable}, 16'd0);
        chk("t4_nodone",  {15'd0, done},      16'd0);
        step();
        chk("t4_sticky",  {15'd0, overrun},   16'd1);
        chk("t4_nodone2", {15'd0, done},      16'd0);
        out_ready = 1'b1;
        kick(12'd1, 1'b1);
        chk("t4_clear",   {15'd0, overrun},   16'd0);
        wait_done("t4_redone", 10);
        step();

        // 5: abort in third RUN cycle, ignored start, zero-length burst
        kick(12'd5, 1'b1);
        step();
        burst_len = 12'd0;
        start     = 1'b1;
        step();
        start     = 1'b0;
        chk("t5_ign_bsy", {15'd0, busy},      16'd1);
        chk("t5_ign_dn",  {15'd0, done},      16'd0);
        chk("t5_w0",      out_data,           16'hFFFF);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_ab_pnen", {15'd0, pn_enable}, 16'd0);
        chk("t5_ab_vld",  {15'd0, out_valid}, 16'd0);
        chk("t5_ab_busy", {15'd0, busy},      16'd0);
        chk("t5_ab_done", {15'd0, done},      16'd0);
        step();
        chk("t5_ab_dn2",  {15'd0, done},      16'd0);
        kick(12'd0, 1'b1);
        chk("t5_z_done",  {15'd0, done},      16'd1);
        chk("t5_z_vld",   {15'd0, out_valid}, 16'd0);
        chk("t5_z_busy",  {15'd0, busy},      16'd0);
        step();
        chk("t5_z_done2", {15'd0, done},      16'd0);
        chk("t5_z_vld2",  {15'd0, out_valid}, 16'd0);

        // 6: reset in DRAIN, then a fresh burst
        out_ready = 1'b0;
        kick(12'd2, 1'b1);
        step(); step(); step();
        chk("t6_drain_b", {15'd0, busy},      16'd1);
        chk("t6_drain_v", {15'd0, out_valid}, 16'd1);
        chk("t6_drain_e", {15'd0, pn_enable}, 16'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_busy",    {15'd0, busy},      16'd0);
        chk("t6_done",    {15'd0, done},      16'd0);
        chk("t6_ovr",     {15'd0, overrun},   16'd0);
        chk("t6_pnen",    {15'd0, pn_enable}, 16'd0);
        chk("t6_mode",    {15'd0, pn_mode},   16'd0);
        chk("t6_valid",   {15'd0, out_valid}, 16'd0);
        chk("t6_last",    {15'd0, out_last},  16'd0);
        chk("t6_data",    out_data,           16'h0000);
`ifdef PN9_BURST_CNT_EN
        chk("t6_cnt0",    burst_cnt,          16'd0);
`endif
        out_ready = 1'b1;
        kick(12'd1, 1'b1);
        step(); step();
        chk("t6_seed",    out_data,           16'hFFFF);
        chk("t6_seedlst", {15'd0, out_last},  16'd1);
        wait_done("t6_redone", 10);
`ifdef PN9_BURST_CNT_EN
        chk("t6_cnt1",    burst_cnt,          16'd1);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
